cmp_track: RTL and testbench

Registered, parametrised magnitude comparator with a valid strobe, run-time signed/unsigned mode, and running statistics. It compares each accepted sample pair `a`/`b` and registers `g`/`l`/`e`. It also tracks the running maximum and minimum of `a` and counts equal results, saturating. It sits after sample capture in data-flow designs that need compare results aligned to a clock edge, plus a per-window summary.

---
 rtl/cmp_pkg.sv | 16 +
 rtl/cmp_core.sv | 32 +++
 rtl/cmp_track.sv | 103 ++++++++++
 tb/tb_cmp_track.sv | 164 ++++++++++++++++
 4 files changed

// File: rtl/cmp_pkg.sv
// Shared types for the cmp_track comparator: tracker state and the one-hot
// three-way compare result.
package cmp_pkg;

    typedef enum logic {
        EMPTY = 1'b0,
        TRACK = 1'b1
    } cmp_state_t;

    typedef struct packed {
        logic g;
        logic l;
        logic e;
    } cmp_res_t;

endpackage

// File: rtl/cmp_core.sv
// Combinational three-way compare of two WIDTH-bit operands, selectable as
// two's-complement or unsigned per call.
module cmp_core
    import cmp_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             signed_mode,
    output cmp_res_t         res
);

    logic [WIDTH-1:0] a_key;
    logic [WIDTH-1:0] b_key;

    // Inverting the sign bit maps two's-complement ordering onto unsigned ordering.
    assign a_key = {a[WIDTH-1] ^ signed_mode, a[WIDTH-2:0]};
    assign b_key = {b[WIDTH-1] ^ signed_mode, b[WIDTH-2:0]};

    always_comb begin
        res = '0;
        if (a == b) begin
            res.e = 1'b1;
        end else if (a_key < b_key) begin
            res.l = 1'b1;
        end else begin
            res.g = 1'b1;
        end
    end

endmodule

// File: rtl/cmp_track.sv
// Registered magnitude comparator with valid strobe, per-sample signed mode,
// and running max/min of A plus a saturating equal-event count.
module cmp_track
    import cmp_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             signed_mode,
    input  logic             clear,
    output logic             out_valid,
    output logic             g,
    output logic             l,
    output logic             e,
    output logic [WIDTH-1:0] max_a,
    output logic [WIDTH-1:0] min_a,
    output logic [CNT_W-1:0] eq_cnt,
    output logic             stats_valid
);

    cmp_state_t state_p1;
    cmp_state_t state_next;
    logic       load_first;
    cmp_res_t   ab_res;
    cmp_res_t   amax_res;
    cmp_res_t   amin_res;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (v == {CNT_W{1'b1}}) ? v : v + CNT_W'(1);
    endfunction

    cmp_core #(.WIDTH(WIDTH)) u_ab (
        .a(a), .b(b), .signed_mode(signed_mode), .res(ab_res)
    );

    cmp_core #(.WIDTH(WIDTH)) u_amax (
        .a(a), .b(max_a), .signed_mode(signed_mode), .res(amax_res)
    );

    cmp_core #(.WIDTH(WIDTH)) u_amin (
        .a(a), .b(min_a), .signed_mode(signed_mode), .res(amin_res)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_p1 <= EMPTY;
        end else begin
            state_p1 <= state_next;
        end
    end

    // A clear in the same cycle as a sample opens a new window with that sample.
    always_comb begin
        state_next = state_p1;
        load_first = (state_p1 == EMPTY) || clear;
        if (in_valid) begin
            state_next = TRACK;
        end else if (clear) begin
            state_next = EMPTY;
        end
    end

    // Stage 1: registered compare result and statistics
    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid <= 1'b0;
            g         <= 1'b0;
            l         <= 1'b0;
            e         <= 1'b0;
            max_a     <= '0;
            min_a     <= '0;
            eq_cnt    <= '0;
        end else begin
            out_valid <= in_valid;
            if (in_valid) begin
                g <= ab_res.g;
                l <= ab_res.l;
                e <= ab_res.e;
                if (load_first) begin
                    max_a  <= a;
                    min_a  <= a;
                    eq_cnt <= CNT_W'(ab_res.e);
                end else begin
                    if (amax_res.g) max_a <= a;
                    if (amin_res.l) min_a <= a;
                    if (ab_res.e) eq_cnt <= sat_inc(eq_cnt);
                end
            end else if (clear) begin
                max_a  <= '0;
                min_a  <= '0;
                eq_cnt <= '0;
            end
        end
    end

    assign stats_valid = (state_p1 == TRACK);

endmodule

// File: tb/tb_cmp_track.sv
// Scoreboard bench for cmp_track (WIDTH=8, CNT_W=2): directed samples push
// hand-computed results, a monitor pops them on every out_valid pulse.
module tb_cmp_track;

    localparam int WIDTH = 8;
    localparam int CNT_W = 2;

    typedef struct packed {
        logic             g;
        logic             l;
        logic             e;
        logic [WIDTH-1:0] mx;
        logic [WIDTH-1:0] mn;
        logic [CNT_W-1:0] eq;
        logic             sv;
    } exp_t;

    logic             clk = 1'b0;
    logic             rst;
    logic             in_valid;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             signed_mode;
    logic             clear;
    logic             out_valid;
    logic             g;
    logic             l;
    logic             e;
    logic [WIDTH-1:0] max_a;
    logic [WIDTH-1:0] min_a;
    logic [CNT_W-1:0] eq_cnt;
    logic             stats_valid;

    int   checks = 0;
    int   errors = 0;
    exp_t sb[$];

    cmp_track #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .a(a), .b(b),
        .signed_mode(signed_mode), .clear(clear), .out_valid(out_valid),
        .g(g), .l(l), .e(e), .max_a(max_a), .min_a(min_a),
        .eq_cnt(eq_cnt), .stats_valid(stats_valid)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h", nm, act, req);
        end
    endtask

    task automatic chk_all_zero(input string nm);
        chk({nm, ".out_valid"}, 32'(out_valid), 0);
        chk({nm, ".gle"}, 32'({g, l, e}), 0);
        chk({nm, ".max_a"}, 32'(max_a), 0);
        chk({nm, ".min_a"}, 32'(min_a), 0);
        chk({nm, ".eq_cnt"}, 32'(eq_cnt), 0);
        chk({nm, ".stats_valid"}, 32'(stats_valid), 0);
    endtask

    task automatic send(input logic [WIDTH-1:0] av, input logic [WIDTH-1:0] bv,
                        input logic sm, input logic clr, input exp_t x);
        @(negedge clk);
        in_valid    = 1'b1;
        a           = av;
        b           = bv;
        signed_mode = sm;
        clear       = clr;
        sb.push_back(x);
    endtask

    task automatic idle(input logic clr);
        @(negedge clk);
        in_valid = 1'b0;
        clear    = clr;
    endtask

    // Monitor: every out_valid pulse consumes one scoreboard entry.
    always @(negedge clk) begin
        exp_t x;
        if (out_valid) begin
            if (sb.size() == 0) begin
                chk("unexpected_out_valid", 1, 0);
            end else begin
                x = sb.pop_front();
                chk("gle", 32'({g, l, e}), 32'({x.g, x.l, x.e}));
                chk("max_a", 32'(max_a), 32'(x.mx));
                chk("min_a", 32'(min_a), 32'(x.mn));
                chk("eq_cnt", 32'(eq_cnt), 32'(x.eq));
                chk("stats_valid", 32'(stats_valid), 32'(x.sv));
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1; in_valid = 1'b1; a = 8'd55; b = 8'd55;
        signed_mode = 1'b0; clear = 1'b0;
        repeat (2) begin
            @(negedge clk);
            chk_all_zero("reset");
        end
        rst = 1'b0; in_valid = 1'b0;

        //         a      b      sm    clr            g     l     e     max    min    eq     sv
        send(8'h80, 8'h7F, 1'b0, 1'b0, '{1'b1, 1'b0, 1'b0, 8'h80, 8'h80, 2'd0, 1'b1});
        send(8'h80, 8'h7F, 1'b1, 1'b0, '{1'b0, 1'b1, 1'b0, 8'h80, 8'h80, 2'd0, 1'b1});
        // Tracking window: 5, 200, 3, 3 against b=3
        send(8'd5,   8'd3, 1'b0, 1'b1, '{1'b1, 1'b0, 1'b0, 8'd5,   8'd5, 2'd0, 1'b1});
        send(8'd200, 8'd3, 1'b0, 1'b0, '{1'b1, 1'b0, 1'b0, 8'd200, 8'd5, 2'd0, 1'b1});
        send(8'd3,   8'd3, 1'b0, 1'b0, '{1'b0, 1'b0, 1'b1, 8'd200, 8'd3, 2'd1, 1'b1});
        send(8'd3,   8'd3, 1'b0, 1'b0, '{1'b0, 1'b0, 1'b1, 8'd200, 8'd3, 2'd2, 1'b1});
        // Saturation of a 2-bit counter
        send(8'd7, 8'd7, 1'b0, 1'b1, '{1'b0, 1'b0, 1'b1, 8'd7, 8'd7, 2'd1, 1'b1});
        send(8'd7, 8'd7, 1'b0, 1'b0, '{1'b0, 1'b0, 1'b1, 8'd7, 8'd7, 2'd2, 1'b1});
        send(8'd7, 8'd7, 1'b0, 1'b0, '{1'b0, 1'b0, 1'b1, 8'd7, 8'd7, 2'd3, 1'b1});
        send(8'd7, 8'd7, 1'b0, 1'b0, '{1'b0, 1'b0, 1'b1, 8'd7, 8'd7, 2'd3, 1'b1});
        send(8'd7, 8'd7, 1'b0, 1'b0, '{1'b0, 1'b0, 1'b1, 8'd7, 8'd7, 2'd3, 1'b1});
        // Clear together with a sample
        send(8'd9, 8'd4, 1'b0, 1'b1, '{1'b1, 1'b0, 1'b0, 8'd9, 8'd9, 2'd0, 1'b1});

        // Clear alone: statistics drop, compare result holds
        idle(1'b1);
        @(negedge clk);
        clear = 1'b0;
        chk("clear.out_valid", 32'(out_valid), 0);
        chk("clear.g_hold", 32'({g, l, e}), 32'(3'b100));
        chk("clear.max_a", 32'(max_a), 0);
        chk("clear.min_a", 32'(min_a), 0);
        chk("clear.eq_cnt", 32'(eq_cnt), 0);
        chk("clear.stats_valid", 32'(stats_valid), 0);

        // Gaps: pulse, hold, pulse; then signed tracking
        send(8'd1, 8'd2, 1'b0, 1'b0, '{1'b0, 1'b1, 1'b0, 8'd1, 8'd1, 2'd0, 1'b1});
        idle(1'b0);
        idle(1'b0);
        chk("gap.out_valid", 32'(out_valid), 0);
        chk("gap.l_hold", 32'({g, l, e}), 32'(3'b010));
        chk("gap.max_hold", 32'(max_a), 1);
        send(8'hFF, 8'h01, 1'b1, 1'b0, '{1'b0, 1'b1, 1'b0, 8'h01, 8'hFF, 2'd0, 1'b1});
        send(8'h7F, 8'h7F, 1'b1, 1'b0, '{1'b0, 1'b0, 1'b1, 8'h7F, 8'hFF, 2'd1, 1'b1});

        // Reset mid-window drops the sample
        @(negedge clk);
        rst = 1'b1; in_valid = 1'b1; a = 8'd4; b = 8'd4; signed_mode = 1'b0;
        @(negedge clk);
        rst = 1'b0; in_valid = 1'b0;
        chk_all_zero("midreset");

        repeat (3) @(negedge clk);
        chk("scoreboard_drained", 32'(sb.size()), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
